// File: rtl/noc_router_sync.sv
// 5-port mesh router: per-input FIFOs, XY routing, per-output round-robin, registered outputs.
// Optional statistics counters are compiled in with `define NOC_ROUTER_STATS_EN.
module noc_router_sync #(
  parameter int WIDTH  = 33,
  parameter int ADDR_W = 2,
  parameter int X_ADDR = 0,
  parameter int Y_ADDR = 0,
  parameter int DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5*WIDTH-1:0]   in_data,
  input  logic [4:0]           in_valid,
  output logic [4:0]           in_ready,
  output logic [5*WIDTH-1:0]   out_data,
  output logic [4:0]           out_valid,
  input  logic [4:0]           out_ready,
  output logic [4:0]           drop_pulse
`ifdef NOC_ROUTER_STATS_EN
  ,
  output logic [5*16-1:0]      stat_flits,
  output logic [15:0]          stat_drops
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] P_N  = 3'd0;
  localparam logic [2:0] P_E  = 3'd1;
  localparam logic [2:0] P_S  = 3'd2;
  localparam logic [2:0] P_W  = 3'd3;
  localparam logic [2:0] P_PE = 3'd4;
  localparam logic [ADDR_W-1:0] X_L = ADDR_W'(X_ADDR);
  localparam logic [ADDR_W-1:0] Y_L = ADDR_W'(Y_ADDR);

  logic [WIDTH-1:0] mem [5][DEPTH];
  logic [AW:0]      wr_ptr [5];
  logic [AW:0]      rd_ptr [5];
  logic [WIDTH-1:0] head [5];
  logic [2:0]       route [5];
  logic [4:0]       empty, full, push, pop, uturn;
  logic [4:0]       req [5];        // req[o][p]: input p wants output o
  logic [2:0]       last_grant [5];
  logic [2:0]       gnt_idx [5];
  logic [WIDTH-1:0] gnt_data [5];
  logic [4:0]       gnt, can_load;
  int               cand;

  function automatic logic [2:0] xy_route(input logic [WIDTH-1:0] f);
    logic [ADDR_W-1:0] dx, dy;
    dx = f[WIDTH-1 -: ADDR_W];
    dy = f[WIDTH-1-ADDR_W -: ADDR_W];
    if (dx > X_L)      return P_E;
    else if (dx < X_L) return P_W;
    else if (dy > Y_L) return P_N;
    else if (dy < Y_L) return P_S;
    else               return P_PE;
  endfunction

  // FIFO status and head routing; a head routing back out of its own side is a U-turn.
  always_comb begin
    for (int p = 0; p < 5; p++) begin
      empty[p] = (wr_ptr[p] == rd_ptr[p]);
      full[p]  = (wr_ptr[p][AW] != rd_ptr[p][AW]) &&
                 (wr_ptr[p][AW-1:0] == rd_ptr[p][AW-1:0]);
      head[p]  = mem[p][rd_ptr[p][AW-1:0]];
      route[p] = xy_route(head[p]);
      uturn[p] = !empty[p] && (p < 4) && (route[p] == 3'(p));
    end
  end

  assign in_ready = ~full;
  assign push     = in_valid & ~full;
  assign can_load = ~out_valid | out_ready;

  always_comb begin
    for (int o = 0; o < 5; o++) begin
      req[o] = '0;
      for (int p = 0; p < 5; p++)
        req[o][p] = !empty[p] && !uturn[p] && (route[p] == 3'(o));
    end
  end

  // Round-robin: the search begins one past the last granted input.
  always_comb begin
    gnt  = '0;
    cand = 0;
    for (int o = 0; o < 5; o++) begin
      gnt_idx[o]  = '0;
      gnt_data[o] = '0;
      for (int k = 0; k < 5; k++) begin
        cand = int'(last_grant[o]) + 1 + k;
        if (cand >= 5) cand = cand - 5;
        if (!gnt[o] && can_load[o] && req[o][cand]) begin
          gnt[o]      = 1'b1;
          gnt_idx[o]  = 3'(cand);
          gnt_data[o] = head[cand];
        end
      end
    end
  end

  always_comb begin
    pop = uturn;
    for (int o = 0; o < 5; o++)
      for (int p = 0; p < 5; p++)
        if (gnt[o] && gnt_idx[o] == 3'(p)) pop[p] = 1'b1;
  end

  // NOTE: FIFO storage has no reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 5; p++)
      if (push[p]) mem[p][wr_ptr[p][AW-1:0]] <= in_data[p*WIDTH +: WIDTH];
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < 5; p++) begin
        wr_ptr[p] <= '0;
        rd_ptr[p] <= '0;
      end
    end else begin
      for (int p = 0; p < 5; p++) begin
        if (push[p]) wr_ptr[p] <= wr_ptr[p] + 1'b1;
        if (pop[p])  rd_ptr[p] <= rd_ptr[p] + 1'b1;
      end
    end
  end

  // last_grant resets to PE so the first search starts at port 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= '0;
      out_data   <= '0;
      drop_pulse <= '0;
      for (int o = 0; o < 5; o++) last_grant[o] <= P_PE;
    end else begin
      drop_pulse <= uturn;
      for (int o = 0; o < 5; o++) begin
        if (can_load[o]) begin
          out_valid[o] <= gnt[o];
          if (gnt[o]) begin
            out_data[o*WIDTH +: WIDTH] <= gnt_data[o];
            last_grant[o]              <= gnt_idx[o];
          end
        end
      end
    end
  end

`ifdef NOC_ROUTER_STATS_EN
  logic [15:0] flit_cnt [5];
  logic [15:0] drop_cnt;
  logic [2:0]  drop_n;
  logic [16:0] drop_sum;

  always_comb begin
    drop_n = '0;
    for (int p = 0; p < 5; p++) drop_n = drop_n + {2'b00, uturn[p]};
    drop_sum = {1'b0, drop_cnt} + 17'(drop_n);
    for (int o = 0; o < 5; o++) stat_flits[o*16 +: 16] = flit_cnt[o];
  end

  assign stat_drops = drop_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt <= '0;
      for (int o = 0; o < 5; o++) flit_cnt[o] <= '0;
    end else begin
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      for (int o = 0; o < 5; o++)
        if (out_valid[o] && out_ready[o] && flit_cnt[o] != 16'hFFFF)
          flit_cnt[o] <= flit_cnt[o] + 16'd1;
    end
  end
`endif

endmodule
